// File: rtl/red_pitaya_iq_avg_block.sv
// Multi-channel sweep-point averager (settle, sum, store) feeding a FWFT result FIFO.
// Define IQ_AVG_SATURATE_EN to clamp accumulators instead of wrapping.
module red_pitaya_iq_avg_block #(
  parameter int CHANNELS   = 2,
  parameter int INBITS     = 24,
  parameter int SUMBITS    = 62,
  parameter int CNTBITS    = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         trig_i,
  input  logic                         clr_i,
  input  logic [CHANNELS*INBITS-1:0]   dat_i,
  input  logic [CNTBITS-1:0]           averages_i,
  input  logic [CNTBITS-1:0]           sleep_i,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic                         rd_i,
  output logic [CHANNELS*SUMBITS-1:0]  rd_data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [DEPTH_LOG2:0]          count_o,
  output logic                         overflow_o
);
  // States: IDLE wait for trig | SLEEP settling | ACC summing samples | STORE push result
  typedef enum logic [1:0] {IDLE, SLEEP, ACC, STORE} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  state_t state_q, state_d;
  logic [CNTBITS-1:0] sleep_cnt_q, sleep_cnt_d, avg_cnt_q, avg_cnt_d;
  logic [CHANNELS-1:0][SUMBITS-1:0] sum_q, sum_d, ext_w, acc_w;
  logic push_w;

  logic [CHANNELS*SUMBITS-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic ovf_q, ovf_d, do_push, do_pop;

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++)
      ext_w[ch] = {{(SUMBITS-INBITS){dat_i[ch*INBITS+INBITS-1]}}, dat_i[ch*INBITS +: INBITS]};
  end

`ifdef IQ_AVG_SATURATE_EN
  localparam logic [SUMBITS-1:0] SUM_MAX = {1'b0, {(SUMBITS-1){1'b1}}};
  localparam logic [SUMBITS-1:0] SUM_MIN = {1'b1, {(SUMBITS-1){1'b0}}};
  logic [CHANNELS-1:0] sat_q, sat_d;
  logic [CHANNELS-1:0][SUMBITS:0] wide_w;

  always_comb begin
    sat_d = sat_q;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      wide_w[ch] = {sum_q[ch][SUMBITS-1], sum_q[ch]} + {ext_w[ch][SUMBITS-1], ext_w[ch]};
      acc_w[ch]  = wide_w[ch][SUMBITS-1:0];
      // once clamped, a channel holds its rail until the next trigger
      if (sat_q[ch]) begin
        acc_w[ch] = sum_q[ch];
      end else if (wide_w[ch][SUMBITS] != wide_w[ch][SUMBITS-1]) begin
        acc_w[ch] = wide_w[ch][SUMBITS] ? SUM_MIN : SUM_MAX;
        if (state_q == ACC) sat_d[ch] = 1'b1;
      end
    end
    if (trig_i) sat_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sat_q <= '0;
    else       sat_q <= sat_d;
  end
`else
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++)
      acc_w[ch] = sum_q[ch] + ext_w[ch];
  end
`endif

  always_comb begin
    state_d     = state_q;
    sleep_cnt_d = sleep_cnt_q;
    avg_cnt_d   = avg_cnt_q;
    sum_d       = sum_q;
    push_w      = 1'b0;
    case (state_q)
      SLEEP: begin
        sleep_cnt_d = sleep_cnt_q - 1'b1;
        if (sleep_cnt_q == CNTBITS'(1)) state_d = (avg_cnt_q == '0) ? STORE : ACC;
      end
      ACC: begin
        sum_d     = acc_w;
        avg_cnt_d = avg_cnt_q - 1'b1;
        if (avg_cnt_q == CNTBITS'(1)) state_d = STORE;
      end
      STORE: begin
        push_w  = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase
    // a trigger restarts the point from any state; a pending STORE still pushes
    if (trig_i) begin
      sleep_cnt_d = sleep_i;
      avg_cnt_d   = averages_i;
      sum_d       = '0;
      if (sleep_i != '0)         state_d = SLEEP;
      else if (averages_i != '0) state_d = ACC;
      else                       state_d = STORE;
    end
  end

  always_comb begin
    do_pop   = rd_i && (count_q != '0);
    do_push  = push_w && ((count_q != FULL_CNT) || rd_i);
    count_d  = count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
    ovf_d    = ovf_q | (push_w && !do_push);
    if (clr_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sleep_cnt_q <= '0;
      avg_cnt_q   <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sleep_cnt_q <= sleep_cnt_d;
      avg_cnt_q   <= avg_cnt_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= sum_q;
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == STORE);
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign rd_data_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];

endmodule
